// File: rtl/bcd_xs3_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_xs3_seq_ctrl
//
// Sequential controller that converts a packed multi-digit BCD word into
// excess-3 (XS3). It uses a single external combinational BCD-to-XS3
// converter, feeding it one digit per clock, least significant digit first.
// Digits greater than 9 produce a zero result nibble and raise a sticky err
// flag. The flag stays set until the next word is accepted.
//
// Ports
//   clk       : clock; all state changes on its rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : bcd_in holds a word to convert
//   in_ready  : block is idle and can accept a word
//   bcd_in    : packed BCD input word, digit 0 in bits [3:0]
//   conv_bcd  : digit presented to the external converter (0 when not converting)
//   conv_xs3  : converter result for conv_bcd, valid in the same cycle
//   out_valid : xs3_out/err hold a completed result
//   out_ready : consumer accepts the result
//   xs3_out   : packed XS3 result, same digit order as bcd_in
//   err       : at least one input digit was greater than 9
//   busy      : controller is not idle
// ---------------------------------------------------------------------------
module bcd_xs3_seq_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [3:0]            conv_bcd,
    input  logic [3:0]            conv_xs3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   xs3_out,
    output logic                  err,
    output logic                  busy
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [IW-1:0]   idx_reg;
    logic [W-1:0]    word_reg;
    logic [W-1:0]    result_reg;
    logic [W-1:0]    result_next;
    logic            err_reg;

    logic [3:0]      digit [DIGITS];
    logic [3:0]      cur_digit;
    logic            cur_bad;
    logic            accept;

    // Split the latched word into digits. Build the next result word so that
    // only the nibble at the current index changes during CONV.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit[gi] = word_reg[4*gi +: 4];
            assign result_next[4*gi +: 4] =
                (state_reg == CONV && idx_reg == IW'(gi))
                    ? (cur_bad ? 4'h0 : conv_xs3)
                    : result_reg[4*gi +: 4];
        end
    endgenerate

    assign cur_digit = digit[idx_reg];
    assign cur_bad   = (cur_digit > 4'd9);

    // in_ready is 1 exactly in IDLE, so an accept is IDLE together with in_valid.
    assign accept    = (state_reg == IDLE) && in_valid;

    // Next-state logic and output decode. All outputs depend only on state and
    // registers, so there is no combinational path from in_valid or out_ready.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        conv_bcd   = 4'h0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                conv_bcd = cur_digit;
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath. The result register is cleared only on accept, so xs3_out keeps
    // the last word's value after DONE->IDLE until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg    <= '0;
            word_reg   <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else if (accept) begin
            idx_reg    <= '0;
            word_reg   <= bcd_in;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else if (state_reg == CONV) begin
            result_reg <= result_next;
            if (cur_bad) begin
                err_reg <= 1'b1;
            end
            // Hold at the last digit instead of wrapping; DONE ignores idx.
            if (idx_reg != LAST_IDX) begin
                idx_reg <= idx_reg + IW'(1);
            end
        end
    end

    assign xs3_out = result_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_xs3_seq_ctrl
//
// Directed plus randomized bench for bcd_xs3_seq_ctrl (DIGITS=4). The
// external BCD-to-XS3 converter is modelled as a continuous add of 3. The
// expected results come from a word-level reference function that works
// directly on the XS3 rule.
// ---------------------------------------------------------------------------
module tb_bcd_xs3_seq_ctrl;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  bcd_in;
    logic [3:0]    conv_bcd;
    logic [3:0]    conv_xs3;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  xs3_out;
    logic          err;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    bcd_xs3_seq_ctrl #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .conv_bcd  (conv_bcd),
        .conv_xs3  (conv_xs3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xs3_out   (xs3_out),
        .err       (err),
        .busy      (busy)
    );

    // External shared converter: combinational BCD -> XS3.
    assign conv_xs3 = conv_bcd + 4'd3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: each digit d<=9 becomes d+3, and each digit >9 becomes 0 and sets err.
    function automatic void ref_model(input logic [W-1:0] w,
                                      output logic [W-1:0] x,
                                      output logic e);
        x = '0;
        e = 1'b0;
        for (int i = 0; i < D; i++) begin
            int d;
            d = int'((w >> (4 * i)) & 16'hF);
            if (d > 9) e = 1'b1;
            else       x = x | W'((d + 3) << (4 * i));
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one word, follow the conversion, hold DONE for 'hold' cycles with
    // out_ready low, then release it and check the return to IDLE.
    task automatic run_word(input string name, input logic [W-1:0] w,
                            input int hold, input bit valid_in_done);
        logic [W-1:0] exp_x;
        logic         exp_e;
        int           edges;
        ref_model(w, exp_x, exp_e);

        chk({name, "/ready_pre"}, 32'(in_ready), 32'd1);
        bcd_in    = w;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        tick();
        chk({name, "/busy_acc"}, 32'(busy), 32'd1);

        // Scramble the input after accept; the result must not change.
        bcd_in   = W'($urandom);
        in_valid = valid_in_done;
        edges    = 0;
        while (out_valid !== 1'b1 && edges < D + 3) begin
            chk({name, "/conv_bcd"}, 32'(conv_bcd),
                (edges < D) ? ((32'(w) >> (4 * edges)) & 32'hF) : 32'd0);
            chk({name, "/ready_conv"}, 32'(in_ready), 32'd0);
            tick();
            edges++;
        end
        chk({name, "/latency"}, 32'(edges), 32'(D));
        chk({name, "/xs3"}, 32'(xs3_out), 32'(exp_x));
        chk({name, "/err"}, 32'(err), 32'(exp_e));
        chk({name, "/ready_done"}, 32'(in_ready), 32'd0);
        chk({name, "/conv_done"}, 32'(conv_bcd), 32'd0);

        for (int h = 0; h < hold; h++) begin
            bcd_in = W'($urandom);
            tick();
            chk({name, "/hold_valid"}, 32'(out_valid), 32'd1);
            chk({name, "/hold_xs3"}, 32'(xs3_out), 32'(exp_x));
            chk({name, "/hold_err"}, 32'(err), 32'(exp_e));
            chk({name, "/hold_ready"}, 32'(in_ready), 32'd0);
        end

        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({name, "/idle_valid"}, 32'(out_valid), 32'd0);
        chk({name, "/idle_ready"}, 32'(in_ready), 32'd1);
        chk({name, "/idle_busy"}, 32'(busy), 32'd0);
        chk({name, "/idle_xs3_kept"}, 32'(xs3_out), 32'(exp_x));
        $display("word %s bcd=%h -> xs3=%h err=%0b (expected %h/%0b) latency=%0d",
                 name, w, xs3_out, err, exp_x, exp_e, edges);
    endtask

    initial begin
        logic [W-1:0] rw;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bcd_in    = '0;

        // Asynchronous reset takes effect before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst/xs3", 32'(xs3_out), 32'd0);
        chk("rst/err", 32'(err), 32'd0);
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/in_ready", 32'(in_ready), 32'd1);
        chk("rst/conv_bcd", 32'(conv_bcd), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // The first edge after release accepts.
        run_word("w1234", 16'h1234, 0, 1'b0);
        run_word("w0909", 16'h0909, 0, 1'b1);
        run_word("w9999", 16'h9999, 0, 1'b0);
        run_word("w12A4", 16'h12A4, 0, 1'b0);
        run_word("w0000", 16'h0000, 0, 1'b0);
        run_word("hold", 16'h4321, 5, 1'b1);

        // Abort a word after its second CONV edge.
        bcd_in   = 16'h8765;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort/xs3", 32'(xs3_out), 32'd0);
        chk("abort/err", 32'(err), 32'd0);
        chk("abort/out_valid", 32'(out_valid), 32'd0);
        chk("abort/busy", 32'(busy), 32'd0);
        chk("abort/in_ready", 32'(in_ready), 32'd1);
        chk("abort/conv_bcd", 32'(conv_bcd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < D + 3; i++) begin
            tick();
            chk("abort/no_valid", 32'(out_valid), 32'd0);
        end
        $display("abort: reset mid-word, no out_valid observed afterwards");
        run_word("w5678", 16'h5678, 0, 1'b0);

        // Randomized words: mostly legal digits, with occasional illegal ones.
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < D; i++) begin
                rw[4*i +: 4] = ($urandom_range(0, 3) == 0)
                               ? 4'($urandom_range(10, 15))
                               : 4'($urandom_range(0, 9));
            end
            run_word($sformatf("rand%0d", n), rw, $urandom_range(0, 3),
                     1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_xs3_seq_ctrl.md
BCD_XS3_SEQ_CTRL -- requirements
Module: bcd_xs3_seq_ctrl

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of BCD digits per word; the legal range is 2..8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: bcd_in holds a word to convert.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-006 The block SHALL have port bcd_in, input, 4*DIGITS bits: packed BCD word, digit 0 = bits [3:0].
REQ-007 The block SHALL have port conv_bcd, output, 4 bits: digit driven to the external shared combinational BCD-to-XS3 converter.
REQ-008 The block SHALL have port conv_xs3, input, 4 bits: the converter result for conv_bcd, valid in the same cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: xs3_out and err hold a completed result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port xs3_out, output, 4*DIGITS bits: packed XS3 result, same digit order as bcd_in.
REQ-012 The block SHALL have port err, output, 1 bit: one or more input digits were greater than 9.
REQ-013 The block SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, CONV and DONE, with a digit index idx of width clog2(DIGITS).
REQ-015 In IDLE: in_ready=1, out_valid=0, conv_bcd=4'h0.
REQ-016 An accept in IDLE occurs when in_valid&&in_ready at an edge; on accept: latch bcd_in, clear the result register and err, set idx=0, go to CONV.
REQ-017 In CONV: conv_bcd SHALL equal latched digit[idx]; digits are processed LSD first, one per cycle.
REQ-018 Each CONV edge with digit[idx]<=9 SHALL write result nibble[idx] <= conv_xs3.
REQ-019 Each CONV edge with digit[idx]>9 SHALL write result nibble[idx] <= 4'h0 and set err, which is sticky until the next accept.
REQ-020 Each CONV edge SHALL increment idx; the edge processing idx==DIGITS-1 goes to DONE, with no idx wrap-around beyond DIGITS-1.
REQ-021 Latency: out_valid SHALL rise exactly DIGITS clock edges after the accept edge.
REQ-022 In DONE: out_valid=1, in_ready=0, conv_bcd=4'h0; xs3_out and err SHALL be stable while out_ready=0.
REQ-023 DONE with out_valid&&out_ready at an edge SHALL go to IDLE; the next accept is possible one cycle later, with no overlap of input and output transfers.
REQ-024 in_valid in CONV or DONE SHALL be ignored (in_ready=0); bcd_in changes after accept SHALL NOT affect the result.
REQ-025 out_ready outside DONE SHALL have no effect.
REQ-026 xs3_out, err, out_valid, in_ready and busy SHALL be driven from registers or state decode only, with no combinational path from in_valid or out_ready.
REQ-027 xs3_out SHALL retain its last value after the DONE->IDLE transition until the next accept clears it.

Reset
REQ-028 rst_n low SHALL immediately force: state=IDLE, idx=0, latched word=0, xs3_out=0, err=0, out_valid=0, busy=0, conv_bcd=0, in_ready=1.
REQ-029 Reset asserted in CONV or DONE SHALL abort the word; no out_valid SHALL appear for the aborted word after rst_n is released.
REQ-030 After rst_n rises, the first accept is possible at the first clk edge.

Verification
REQ-031 Bench: rst_n=0 -> xs3_out=0, err=0, out_valid=0, busy=0, in_ready=1; release -> accept at first edge.
REQ-032 Bench: DIGITS=4, bcd_in=16'h1234, out_ready=1 -> out_valid 4 edges after accept, xs3_out=16'h4567, err=0; IDLE next cycle.
REQ-033 Bench: bcd_in=16'h0909 and 16'h9999 back-to-back -> 16'h3C3C, then 16'hCCCC; each err=0; in_ready=0 during the first word.
REQ-034 Bench: bcd_in=16'h12A4 -> xs3_out=16'h4507, err=1; the next word 16'h0000 -> 16'h3333, err=0.
REQ-035 Bench: out_ready=0 for 5 cycles in DONE while in_valid=1 -> output stable, in_ready=0, no accept; out_ready=1 -> IDLE next edge.
REQ-036 Bench: rst_n pulsed low after the 2nd CONV edge -> outputs zero immediately, no out_valid; a new word 16'h5678 -> 16'h89AB.
